// File: rtl/dnn_weight_fetch.sv
// Weight-block fetcher: prefetches one 64-byte line ahead into pf_buf and
// hands it to the loader's out_buf on request, with sticky done/err status.
module dnn_weight_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [11:0] num_blocks,
    input  logic        req_mem,
    output logic [63:0] mem_data [7:0],
    output logic        mem_ready,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_gnt,
    input  logic        rd_valid,
    input  logic [63:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, RECV} state_e;

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [11:0] nblk_q, nblk_d;
    logic [11:0] issued_q, issued_d;
    logic [11:0] delivered_q, delivered_d;
    logic [2:0]  beat_q, beat_d;
    logic        pend_q, pend_d;
    logic        pf_valid_q, pf_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic [63:0] pf_buf_q [7:0];
    logic [63:0] pf_buf_d [7:0];
    logic [63:0] out_buf_q [7:0];
    logic [63:0] out_buf_d [7:0];
    logic        xfer;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        nblk_d      = nblk_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        beat_d      = beat_q;
        pend_d      = pend_q;
        pf_valid_d  = pf_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        pf_buf_d    = pf_buf_q;
        out_buf_d   = out_buf_q;

        case (state_q)
            IDLE: begin
                if (busy_q && !pf_valid_q && (issued_q < nblk_q)) state_d = REQ;
            end
            REQ: begin
                if (rd_gnt) begin
                    issued_d = issued_q + 12'd1;
                    beat_d   = '0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (rd_valid) begin
                    pf_buf_d[beat_q] = rd_data;
                    beat_d           = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        pf_valid_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests never queue: one outstanding, anything beyond is an overrun.
        if (req_mem) begin
            if (!busy_q || pend_q) err_d = 1'b1;
            else                   pend_d = 1'b1;
        end

        // Transfer uses registered pf_valid, so a line finishing this edge waits one cycle.
        xfer = busy_q && pf_valid_q && (pend_q || req_mem);
        if (xfer) begin
            out_buf_d   = pf_buf_q;
            pf_valid_d  = 1'b0;
            pend_d      = 1'b0;
            delivered_d = delivered_q + 12'd1;
            ready_d     = 1'b1;
            if (delivered_d == nblk_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end

        if (start && !busy_q) begin
            base_d      = base_addr;
            nblk_d      = num_blocks;
            issued_d    = '0;
            delivered_d = '0;
            beat_d      = '0;
            pf_valid_d  = 1'b0;
            err_d       = 1'b0;
            ready_d     = 1'b0;
            state_d     = IDLE;
            if (num_blocks == '0) begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pend_d = 1'b0;
            end else begin
                done_d = 1'b0;
                busy_d = 1'b1;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            nblk_q      <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            pf_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            pf_buf_q    <= '{default: '0};
            out_buf_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nblk_q      <= nblk_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            beat_q      <= beat_d;
            pend_q      <= pend_d;
            pf_valid_q  <= pf_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            pf_buf_q    <= pf_buf_d;
            out_buf_q   <= out_buf_d;
        end
    end

    assign rd_req    = (state_q == REQ);
    assign rd_addr   = (state_q == REQ) ? (base_q + {14'd0, issued_q, 6'd0}) : '0;
    assign mem_data  = out_buf_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dnn_weight_fetch.sv
// Directed bench for dnn_weight_fetch: each task drives one scenario and
// checks outputs #1 after the rising edge against hand-computed values.
module tb_dnn_weight_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [11:0] num_blocks;
    logic        req_mem;
    logic [63:0] mem_data [7:0];
    logic        mem_ready;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    dnn_weight_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_blocks(num_blocks), .req_mem(req_mem), .mem_data(mem_data),
        .mem_ready(mem_ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] beat_word(input int blk, input int i);
        return {16'hC0DE, blk[15:0], 24'h0, i[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [11:0] n);
        base_addr  = b;
        num_blocks = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_rd_req(output logic ok, output logic [31:0] addr);
        ok   = 1'b0;
        addr = '0;
        for (int k = 0; k < 50; k++) begin
            if (rd_req === 1'b1) begin
                ok   = 1'b1;
                addr = rd_addr;
                break;
            end
            tick();
        end
    endtask

    task automatic grant();
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
    endtask

    task automatic send_beats(input int blk, input int first, input int cnt, input int gap);
        for (int i = first; i < first + cnt; i++) begin
            rd_valid = 1'b1;
            rd_data  = beat_word(blk, i);
            tick();
            rd_valid = 1'b0;
            if (i != 7) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; base_addr = '0; num_blocks = '0; req_mem = 0;
        rd_gnt = 0; rd_valid = 0; rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {busy, done, err}); end
        total++; if (rd_req !== 1'b0 || rd_addr !== 32'h0) begin bad++; $display("FAIL reset_rd got=%b/%h exp=0/0", rd_req, rd_addr); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_data[i] !== 64'h0) begin bad++; $display("FAIL reset_data[%0d] got=%h exp=0", i, mem_data[i]); end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic ok; logic [31:0] a;
        do_start(32'h1000, 12'd2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h1000) begin bad++; $display("FAIL basic_addr0 got=%h ok=%b exp=00001000", a, ok); end
        grant();
        total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL basic_req_drop got=%b exp=0", rd_req); end
        send_beats(0, 0, 8, 0);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL basic_early_ready got=%b exp=0", mem_ready); end
        tick();
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL basic_ready0 got=%b exp=1", mem_ready); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_data[i] !== beat_word(0, i)) begin bad++; $display("FAIL basic_data0[%0d] got=%h exp=%h", i, mem_data[i], beat_word(0, i)); end
        end
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h1040) begin bad++; $display("FAIL basic_addr1 got=%h ok=%b exp=00001040", a, ok); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL basic_single_pulse got=%b exp=0", mem_ready); end
        grant();
        send_beats(1, 0, 8, 0);
        repeat (2) tick();
        total++; if (mem_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL basic_hold got=%b%b exp=00", mem_ready, done); end
        total++; if (mem_data[3] !== beat_word(0, 3)) begin bad++; $display("FAIL basic_stable got=%h exp=%h", mem_data[3], beat_word(0, 3)); end
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", mem_ready); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done got=%b%b exp=10", done, busy); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_data[i] !== beat_word(1, i)) begin bad++; $display("FAIL basic_data1[%0d] got=%h exp=%h", i, mem_data[i], beat_word(1, i)); end
        end
        tick();
        total++; if (mem_ready !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL basic_after got=%b%b%b exp=010", mem_ready, done, err); end
    endtask

    task automatic test_overrun();
        logic ok; logic [31:0] a;
        do_start(32'h3000, 12'd1);
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h3000) begin bad++; $display("FAIL ovr_addr got=%h ok=%b exp=00003000", a, ok); end
        grant();
        send_beats(3, 0, 8, 0);
        tick();
        total++; if (mem_ready !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ovr_deliver got=%b%b exp=11", mem_ready, done); end
        tick();
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovr_err got=%b exp=1", err); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL ovr_no_ready got=%b exp=0", mem_ready); end
        total++; if (mem_data[5] !== beat_word(3, 5)) begin bad++; $display("FAIL ovr_data got=%h exp=%h", mem_data[5], beat_word(3, 5)); end
        tick();
        total++; if (mem_ready !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b%b%b exp=011", mem_ready, err, done); end
    endtask

    task automatic test_gapped();
        logic ok; logic [31:0] a; int held;
        do_start(32'h5000, 12'd1);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL gap_err_clear got=%b exp=0", err); end
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL gap_double_req got=%b exp=1", err); end
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h5000) begin bad++; $display("FAIL gap_addr got=%h ok=%b exp=00005000", a, ok); end
        held = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rd_req === 1'b1 && rd_addr === 32'h5000) held++;
        end
        total++; if (held !== 5) begin bad++; $display("FAIL gap_req_hold got=%0d exp=5", held); end
        grant();
        send_beats(5, 0, 8, 2);
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL gap_early got=%b exp=0", mem_ready); end
        tick();
        total++; if (mem_ready !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL gap_ready got=%b%b exp=11", mem_ready, done); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_data[i] !== beat_word(5, i)) begin bad++; $display("FAIL gap_data[%0d] got=%h exp=%h", i, mem_data[i], beat_word(5, i)); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic ok; logic [31:0] a;
        do_start(32'h7000, 12'd1);
        wait_rd_req(ok, a);
        grant();
        send_beats(7, 0, 3, 0);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, err, rd_req} !== 4'b0000) begin bad++; $display("FAIL rmid_clear got=%b exp=0000", {busy, done, err, rd_req}); end
        total++; if (mem_data[0] !== 64'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", mem_data[0]); end
        tick();
        rst_n = 1'b1;
        send_beats(7, 3, 5, 0);
        tick();
        total++; if (mem_ready !== 1'b0 || rd_req !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b%b exp=00", mem_ready, rd_req); end
        do_start(32'h2000, 12'd1);
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h2000) begin bad++; $display("FAIL rmid_addr got=%h ok=%b exp=00002000", a, ok); end
        grant();
        send_beats(9, 0, 8, 0);
        tick();
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", mem_ready); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem_data[i] !== beat_word(9, i)) begin bad++; $display("FAIL rmid_data[%0d] got=%h exp=%h", i, mem_data[i], beat_word(9, i)); end
        end
        tick();
    endtask

    task automatic test_wrap();
        logic ok; logic [31:0] a;
        do_start(32'hFFFF_FFC0, 12'd2);
        do_start(32'h1234_0000, 12'd5);
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'hFFFF_FFC0) begin bad++; $display("FAIL wrap_addr0 got=%h ok=%b exp=ffffffc0", a, ok); end
        grant();
        send_beats(11, 0, 8, 0);
        tick();
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready0 got=%b exp=1", mem_ready); end
        wait_rd_req(ok, a);
        total++; if (!ok || a !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr1 got=%h ok=%b exp=00000000", a, ok); end
        grant();
        send_beats(12, 0, 8, 0);
        tick();
        req_mem = 1'b1;
        tick();
        req_mem = 1'b0;
        total++; if (mem_ready !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wrap_done got=%b%b%b exp=110", mem_ready, done, busy); end
        total++; if (mem_data[7] !== beat_word(12, 7)) begin bad++; $display("FAIL wrap_data got=%h exp=%h", mem_data[7], beat_word(12, 7)); end
        tick();
    endtask

    task automatic test_zero_blocks();
        int seen;
        do_start(32'h4000, 12'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got=%b%b exp=10", done, busy); end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rd_req !== 1'b0 || mem_ready !== 1'b0) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL zero_quiet got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_gapped();
        test_reset_mid();
        test_wrap();
        test_zero_blocks();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
